// File: rtl/sd_sector_packer_pkg.sv
// Shared types, constants and the CRC16 byte step for the SD sector packer.
package sd_sector_packer_pkg;

    localparam int unsigned SECTOR_BYTES_DEF = 512;
    localparam logic [15:0] CRC16_POLY       = 16'h1021;
    localparam logic [15:0] CRC16_INIT       = 16'h0000;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_PAD   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
    } sec_beat_t;

    // CRC16-CCITT, MSB-first, one byte per call.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ CRC16_POLY;
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_sector_packer_sector_ram.sv
// Sector buffer: one write port, one read port, registered read (block RAM).
module sd_sector_packer_sector_ram #(
    parameter int unsigned DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [7:0]               wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [7:0]               rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/sd_sector_packer.sv
// Packs drain-stage bytes into SD sectors, pads on flush, streams with addr/markers.
// Optional CRC16 on the outgoing stream: define SD_SECTOR_PACKER_CRC16_EN.
module sd_sector_packer
    import sd_sector_packer_pkg::*;
#(
    parameter int unsigned       SECTOR_BYTES = SECTOR_BYTES_DEF,
    parameter logic [7:0]        PAD_BYTE     = 8'h00,
    parameter int unsigned       ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] START_SECTOR = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [7:0]                      byte_data_i,
    input  logic                            byte_start_i,
    output logic                            byte_finish_o,
    input  logic                            flush_i,
    output logic                            sec_valid_o,
    input  logic                            sec_ready_i,
    output logic [7:0]                      sec_data_o,
    output logic                            sec_first_o,
    output logic                            sec_last_o,
    output logic [ADDR_W-1:0]               sec_addr_o,
    output logic [15:0]                     sec_crc_o,
    output logic [$clog2(SECTOR_BYTES):0]   fill_count_o,
    output logic [15:0]                     sector_count_o,
    output logic                            overrun_o
);

    localparam int unsigned AW       = $clog2(SECTOR_BYTES);
    localparam int unsigned CW       = AW + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(SECTOR_BYTES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(SECTOR_BYTES);

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     iss_ptr_q, iss_ptr_d;
    logic              s1_v_q, s1_v_d;
    logic [AW-1:0]     s1_idx_q, s1_idx_d;
    sec_beat_t         beat_q, beat_d;
    logic              sec_valid_q, sec_valid_d;
    logic              pend_v_q, pend_v_d;
    logic [7:0]        pend_q, pend_d;
    logic              finish_q, finish_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [CW-1:0]     fill_q, fill_d;
    logic              overrun_q, overrun_d;

    logic              ram_we, ram_re;
    logic [7:0]        ram_wdata, ram_rdata;
    logic              advance, beat_load;

    sd_sector_packer_sector_ram #(.DEPTH(SECTOR_BYTES)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (iss_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // Output stage may reload when empty or when its beat is being taken.
    assign advance   = !sec_valid_q || sec_ready_i;
    assign beat_load = (state_q == ST_DRAIN) && advance && s1_v_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        iss_ptr_d   = iss_ptr_q;
        s1_v_d      = s1_v_q;
        s1_idx_d    = s1_idx_q;
        beat_d      = beat_q;
        sec_valid_d = sec_valid_q;
        pend_v_d    = pend_v_q;
        pend_d      = pend_q;
        finish_d    = 1'b0;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        overrun_d   = overrun_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_wdata   = byte_data_i;

        // Outside FILL the drain stage is held off by a single-entry pending slot.
        if (state_q != ST_FILL && byte_start_i) begin
            if (pend_v_q) begin
                overrun_d = 1'b1;
            end else begin
                pend_v_d = 1'b1;
                pend_d   = byte_data_i;
            end
        end

        case (state_q)
            ST_FILL: begin
                if (pend_v_q) begin
                    ram_we    = 1'b1;
                    ram_wdata = pend_q;
                    pend_v_d  = byte_start_i;
                    pend_d    = byte_data_i;
                end else if (byte_start_i) begin
                    ram_we = 1'b1;
                end
                if (ram_we) begin
                    finish_d = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (wr_ptr_q == LAST_IDX) state_d = ST_DRAIN;
                    else if (flush_i)         state_d = ST_PAD;
                end else if (flush_i && wr_ptr_q != '0) begin
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                ram_we    = 1'b1;
                ram_wdata = PAD_BYTE;
                wr_ptr_d  = wr_ptr_q + AW'(1);
                if (wr_ptr_q == LAST_IDX) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (advance) begin
                    if (s1_v_q) begin
                        beat_d.data  = ram_rdata;
                        beat_d.first = (s1_idx_q == '0);
                        beat_d.last  = (s1_idx_q == LAST_IDX);
                    end
                    sec_valid_d = s1_v_q;
                    ram_re      = (iss_ptr_q != FULL_CNT);
                    s1_v_d      = ram_re;
                    if (ram_re) begin
                        s1_idx_d  = iss_ptr_q[AW-1:0];
                        iss_ptr_d = iss_ptr_q + CW'(1);
                    end
                end
                if (sec_valid_q && sec_ready_i && beat_q.last) begin
                    state_d   = ST_FILL;
                    wr_ptr_d  = '0;
                    iss_ptr_d = '0;
                    addr_d    = addr_q + ADDR_W'(1);
                    cnt_d     = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_FILL;
        endcase

        fill_d = (state_d == ST_DRAIN) ? FULL_CNT : CW'(wr_ptr_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            wr_ptr_q    <= '0;
            iss_ptr_q   <= '0;
            s1_v_q      <= 1'b0;
            s1_idx_q    <= '0;
            beat_q      <= '0;
            sec_valid_q <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_q      <= '0;
            finish_q    <= 1'b0;
            addr_q      <= START_SECTOR;
            cnt_q       <= '0;
            fill_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            iss_ptr_q   <= iss_ptr_d;
            s1_v_q      <= s1_v_d;
            s1_idx_q    <= s1_idx_d;
            beat_q      <= beat_d;
            sec_valid_q <= sec_valid_d;
            pend_v_q    <= pend_v_d;
            pend_q      <= pend_d;
            finish_q    <= finish_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SD_SECTOR_PACKER_CRC16_EN
    logic [15:0] crc_acc_q, crc_acc_d, crc_q, crc_d;

    // Accumulated as beats enter the output register so the result is ready with sec_last.
    always_comb begin
        crc_acc_d = crc_acc_q;
        crc_d     = crc_q;
        if (beat_load) begin
            crc_acc_d = crc16_byte((s1_idx_q == '0) ? CRC16_INIT : crc_acc_q, ram_rdata);
            if (s1_idx_q == LAST_IDX) crc_d = crc_acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_acc_q <= CRC16_INIT;
            crc_q     <= '0;
        end else begin
            crc_acc_q <= crc_acc_d;
            crc_q     <= crc_d;
        end
    end

    assign sec_crc_o = crc_q;
`else
    assign sec_crc_o = 16'h0000;
`endif

    assign byte_finish_o  = finish_q;
    assign sec_valid_o    = sec_valid_q;
    assign sec_data_o     = beat_q.data;
    assign sec_first_o    = beat_q.first;
    assign sec_last_o     = beat_q.last;
    assign sec_addr_o     = addr_q;
    assign fill_count_o   = fill_q;
    assign sector_count_o = cnt_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_sd_sector_packer.sv
// Scoreboarded random bench for sd_sector_packer against a sector-level reference model.
module tb_sd_sector_packer;

    localparam int unsigned SB    = 512;
    localparam int unsigned CW    = $clog2(SB) + 1;
    localparam logic [7:0]  PAD   = 8'h00;
    localparam logic [31:0] START = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_start = 1'b0;
    logic          byte_finish_o;
    logic          flush = 1'b0;
    logic          sec_valid_o;
    logic          sec_ready = 1'b1;
    logic [7:0]    sec_data_o;
    logic          sec_first_o, sec_last_o;
    logic [31:0]   sec_addr_o;
    logic [15:0]   sec_crc_o;
    logic [CW-1:0] fill_count_o;
    logic [15:0]   sector_count_o;
    logic          overrun_o;

    sd_sector_packer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .byte_data_i    (byte_data),
        .byte_start_i   (byte_start),
        .byte_finish_o  (byte_finish_o),
        .flush_i        (flush),
        .sec_valid_o    (sec_valid_o),
        .sec_ready_i    (sec_ready),
        .sec_data_o     (sec_data_o),
        .sec_first_o    (sec_first_o),
        .sec_last_o     (sec_last_o),
        .sec_addr_o     (sec_addr_o),
        .sec_crc_o      (sec_crc_o),
        .fill_count_o   (fill_count_o),
        .sector_count_o (sector_count_o),
        .overrun_o      (overrun_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        first;
        logic        last;
        logic [31:0] addr;
        logic [15:0] crc;
    } beat_t;

    beat_t       sb_q[$];
    logic [7:0]  mbuf[$];
    int unsigned maddr = START;
    int unsigned mcnt  = 0;

    int n_vec = 0, n_err = 0;
    int cyc = 0, fin_cnt = 0, last_fin_cyc = -1, last_done_cyc = -1;
    bit rdy_rand = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: a sector is the captured bytes padded to SB, CRC over the whole image.
    task automatic model_emit();
        logic [7:0]  img [SB];
        logic [15:0] c;
        beat_t       bt;
        c = 16'h0000;
        for (int i = 0; i < SB; i++) img[i] = (i < mbuf.size()) ? mbuf[i] : PAD;
`ifdef SD_SECTOR_PACKER_CRC16_EN
        for (int i = 0; i < SB; i++) begin
            c = c ^ {img[i], 8'h00};
            repeat (8) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
`endif
        for (int i = 0; i < SB; i++) begin
            bt.d     = img[i];
            bt.first = (i == 0);
            bt.last  = (i == SB - 1);
            bt.addr  = maddr;
            bt.crc   = c;
            sb_q.push_back(bt);
        end
        mbuf.delete();
        maddr++;
        mcnt++;
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        sec_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
    end

    // Monitor: pops the scoreboard on each transfer and checks stall stability.
    logic       stall_q = 1'b0;
    logic [7:0] hold_d;
    logic [1:0] hold_m;
    beat_t      exp_b;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_q) begin
                chk("stall_valid", 32'(sec_valid_o), 32'd1);
                chk("stall_data", 32'(sec_data_o), 32'(hold_d));
                chk("stall_marks", 32'({sec_first_o, sec_last_o}), 32'(hold_m));
            end
            if (sec_valid_o && sec_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", 32'(sec_data_o), 32'hFFFF_FFFF);
                end else begin
                    exp_b = sb_q.pop_front();
                    chk("sec_data", 32'(sec_data_o), 32'(exp_b.d));
                    chk("sec_first", 32'(sec_first_o), 32'(exp_b.first));
                    chk("sec_last", 32'(sec_last_o), 32'(exp_b.last));
                    chk("sec_addr", sec_addr_o, exp_b.addr);
                    if (exp_b.last) begin
                        chk("sec_crc", 32'(sec_crc_o), 32'(exp_b.crc));
                        last_done_cyc = cyc;
                    end
                end
            end
            stall_q = sec_valid_o && !sec_ready;
            hold_d  = sec_data_o;
            hold_m  = {sec_first_o, sec_last_o};
        end else begin
            stall_q = 1'b0;
        end
        if (byte_finish_o) begin
            fin_cnt++;
            last_fin_cyc = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit fl);
        @(posedge clk); #1;
        byte_data  = d;
        byte_start = 1'b1;
        flush      = fl;
        @(posedge clk); #1;
        byte_start = 1'b0;
        flush      = 1'b0;
        chk("byte_finish", 32'(byte_finish_o), 32'd1);
        mbuf.push_back(d);
        if (mbuf.size() == SB) model_emit();
        else if (fl) model_emit();
    endtask

    task automatic send_flush();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        if (mbuf.size() > 0) model_emit();
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sb_q.size() != 0 || sec_valid_o) && k < 20000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 20000) chk("drain_timeout", 32'd1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("sector_count", 32'(sector_count_o), 32'(mcnt[15:0]));
        chk("sec_addr_next", sec_addr_o, maddr);
        chk("fill_after_drain", 32'(fill_count_o), 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_byte_finish", 32'(byte_finish_o), 32'd0);
        chk("rst_sec_valid", 32'(sec_valid_o), 32'd0);
        chk("rst_sec_data", 32'(sec_data_o), 32'd0);
        chk("rst_sec_first", 32'(sec_first_o), 32'd0);
        chk("rst_sec_last", 32'(sec_last_o), 32'd0);
        chk("rst_sec_addr", sec_addr_o, START);
        chk("rst_sec_crc", 32'(sec_crc_o), 32'd0);
        chk("rst_fill_count", 32'(fill_count_o), 32'd0);
        chk("rst_sector_count", 32'(sector_count_o), 32'd0);
        chk("rst_overrun", 32'(overrun_o), 32'd0);
    endtask

    initial begin
        int c0, k, n;
        bit comb;

        #12;
        chk_reset_vals();
        @(negedge clk) rst_n = 1'b1;

        // Incrementing sector, ready held high.
        for (int i = 0; i < SB; i++) send_byte(8'(i), 1'b0);
        wait_drain();

        // Partial sector then flush; then flush with nothing buffered.
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        @(posedge clk); #1;
        chk("fill_before_pad", 32'(fill_count_o), 32'd3);
        send_flush();
        wait_drain();
        send_flush();
        repeat (20) @(posedge clk);
        #1;
        chk("empty_flush_valid", 32'(sec_valid_o), 32'd0);
        chk("empty_flush_fill", 32'(fill_count_o), 32'd0);

        // All-FF sector (CRC case), then random data with back-pressure.
        for (int i = 0; i < SB; i++) send_byte(8'hFF, 1'b0);
        wait_drain();
        rdy_rand = 1'b1;
        for (int i = 0; i < SB; i++) send_byte(8'($urandom), 1'b0);
        wait_drain();

        // Byte arriving mid-drain is held; a second one overruns and is lost.
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b0);
        send_flush();
        k = 0;
        while (!sec_valid_o && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 2000) chk("drain_start_timeout", 32'd1, 32'd0);
        c0 = fin_cnt;
        @(posedge clk); #1;
        byte_data = 8'h5A; byte_start = 1'b1;
        @(posedge clk); #1;
        byte_start = 1'b0;
        chk("finish_held", 32'(byte_finish_o), 32'd0);
        @(posedge clk); #1;
        byte_data = 8'hC3; byte_start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        byte_start = 1'b0; flush = 1'b0;
        chk("overrun_set", 32'(overrun_o), 32'd1);
        mbuf.push_back(8'h5A);
        k = 0;
        while (fin_cnt == c0 && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 5000) chk("pending_finish_timeout", 32'd1, 32'd0);
        chk("pending_finish_delay", 32'(last_fin_cyc - last_done_cyc), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("single_finish", 32'(fin_cnt - c0), 32'd1);
        chk("sector_count_pend", 32'(sector_count_o), 32'(mcnt[15:0]));
        chk("fill_after_pending", 32'(fill_count_o), 32'd1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        wait_drain();
        chk("overrun_sticky", 32'(overrun_o), 32'd1);

        // Random lengths; first pass fills exactly with a coincident (dropped) flush.
        for (int s = 0; s < 4; s++) begin
            rdy_rand = 1'($urandom % 2);
            n    = (s == 0) ? SB : int'($urandom_range(1, SB));
            comb = (s == 0) ? 1'b1 : 1'($urandom % 2);
            for (int i = 0; i < n; i++) send_byte(8'($urandom), (i == n - 1) && comb);
            if (!comb && n < SB) send_flush();
            wait_drain();
        end

        // Reset mid-sector discards the partial buffer.
        for (int i = 0; i < 100; i++) send_byte(8'($urandom), 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk_reset_vals();
        mbuf.delete();
        maddr = START;
        mcnt  = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < SB; i++) send_byte(8'($urandom), 1'b0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
